// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, 3-sample majority vote per bit,
// false-start rejection, parity/framing/break flags and an output FIFO with a
// valid/ready handshake.
module uart_rx_param #(
    parameter int unsigned CLKS_PER_BIT = 8474,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_uart_rx,
    input  logic                 o_tready,
    output logic                 o_tvalid,
    output logic [DATA_BITS-1:0] o_tdata,
    output logic [2:0]           o_tuser,
    output logic                 o_overflow,
    input  logic                 i_ovf_clr,
    output logic                 o_busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned H  = CLKS_PER_BIT / 2;
    localparam int unsigned IW = $clog2(DATA_BITS);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = DATA_BITS + 3;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_HIGH = 3'd5;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs, rxs_prev_q, fall;
    logic [2:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q;
    logic [IW-1:0]          bit_idx_q;
    logic                   stop_idx_q, stop_last;
    logic [DATA_BITS-1:0]   data_q;
    logic                   par_bit_q, stop0_q, par_err_q, frame_err_q;
    logic                   v0_q, v1_q, maj;
    logic                   at_vote, at_push, at_end, brk, push;
    logic [EW-1:0]          entry;

    logic [EW-1:0]          mem_q [FIFO_DEPTH];
    logic [AW:0]            wr_ptr_q, rd_ptr_q;
    logic                   empty, full, pop, wr_en, ovf_set;
    logic [EW-1:0]          head;

    assign rxs       = sync_q[SYNC_STAGES-1];
    assign fall      = rxs_prev_q & ~rxs;
    assign maj       = (v0_q & v1_q) | (v0_q & rxs) | (v1_q & rxs);
    assign at_vote   = cnt_q == CW'(H + 1);
    assign at_push   = cnt_q == CW'(H + 2);
    assign at_end    = cnt_q == CW'(CLKS_PER_BIT - 1);
    assign stop_last = (STOP_BITS == 1) ? 1'b1 : stop_idx_q;
    assign brk       = (data_q == '0) && ((PARITY == 0) || !par_bit_q) && !stop0_q;
    assign entry     = {brk, frame_err_q | brk, par_err_q, data_q};

    // Synchroniser preset to idle-high so reset never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= '1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], i_uart_rx};
            rxs_prev_q <= rxs;
        end
    end

    // Next-state decode; the frame is pushed one cycle after the last stop vote.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE:      if (fall) state_d = S_START;
            S_START: begin
                if (at_vote && maj) state_d = S_IDLE;
                else if (at_end)    state_d = S_DATA;
            end
            S_DATA: begin
                if (at_end && bit_idx_q == IW'(DATA_BITS - 1))
                    state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY:    if (at_end) state_d = S_STOP;
            S_STOP: begin
                if (at_push && stop_last) begin
                    push    = 1'b1;
                    state_d = brk ? S_WAIT_HIGH : S_IDLE;
                end
            end
            S_WAIT_HIGH: if (rxs) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Bit timer, vote samples and per-frame capture registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            data_q      <= '0;
            par_bit_q   <= 1'b0;
            stop0_q     <= 1'b1;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            v0_q        <= 1'b1;
            v1_q        <= 1'b1;
        end else if (state_q == S_IDLE) begin
            cnt_q <= '0;
            if (fall) begin
                bit_idx_q   <= '0;
                stop_idx_q  <= 1'b0;
                data_q      <= '0;
                par_bit_q   <= 1'b0;
                stop0_q     <= 1'b1;
                par_err_q   <= 1'b0;
                frame_err_q <= 1'b0;
            end
        end else begin
            cnt_q <= at_end ? '0 : cnt_q + CW'(1);
            if (cnt_q == CW'(H - 1)) v0_q <= rxs;
            if (cnt_q == CW'(H))     v1_q <= rxs;
            if (at_vote) begin
                case (state_q)
                    S_DATA:   data_q[bit_idx_q] <= maj;
                    S_PARITY: begin
                        par_bit_q <= maj;
                        par_err_q <= ((^data_q) ^ maj) != (PARITY == 1);
                    end
                    S_STOP: begin
                        if (!maj)        frame_err_q <= 1'b1;
                        if (!stop_idx_q) stop0_q     <= maj;
                    end
                    default: ;
                endcase
            end
            if (at_end && state_q == S_DATA) bit_idx_q  <= bit_idx_q + IW'(1);
            if (at_end && state_q == S_STOP) stop_idx_q <= 1'b1;
        end
    end

    // FIFO: extra pointer bit separates full from empty.
    assign empty   = wr_ptr_q == rd_ptr_q;
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = o_tvalid & o_tready;
    assign wr_en   = push & (~full | pop);
    assign ovf_set = push & full & ~pop;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    // FIFO storage and pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q[AW-1:0]] <= entry;
                wr_ptr_q                <= wr_ptr_q + (AW + 1)'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
        end
    end

    // Sticky overflow; a simultaneous set beats the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          o_overflow <= 1'b0;
        else if (ovf_set)   o_overflow <= 1'b1;
        else if (i_ovf_clr) o_overflow <= 1'b0;
    end

    assign o_tvalid = ~empty;
    assign o_tdata  = head[DATA_BITS-1:0];
    assign o_tuser  = head[EW-1:DATA_BITS];
    assign o_busy   = state_q != S_IDLE;

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised self-checking bench: one 8N1 and one 8E1 receiver, frames built
// from the serial format and checked against an expected-beat queue.
module tb_uart_rx_param;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    logic rx0, rx1, rdy0, rdy1, clr0, clr1;
    logic tvalid0, tvalid1, ovf0, ovf1, busy0, busy1;
    logic [7:0] tdata0, tdata1;
    logic [2:0] tuser0, tuser1;

    int n_checks = 0;
    int n_errors = 0;

    logic [10:0] exp0[$], exp1[$], got0[$], got1[$];
    logic        ovf0_m;

    always #5 clk = ~clk;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                    .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) u_dut_n (
        .clk(clk), .reset(reset), .i_uart_rx(rx0), .o_tready(rdy0), .o_tvalid(tvalid0),
        .o_tdata(tdata0), .o_tuser(tuser0), .o_overflow(ovf0), .i_ovf_clr(clr0), .o_busy(busy0)
    );

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                    .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) u_dut_e (
        .clk(clk), .reset(reset), .i_uart_rx(rx1), .o_tready(rdy1), .o_tvalid(tvalid1),
        .o_tdata(tdata1), .o_tuser(tuser1), .o_overflow(ovf1), .i_ovf_clr(clr1), .o_busy(busy1)
    );

    // Record every handshake beat away from the active edge.
    always @(negedge clk) begin
        if (!reset && tvalid0 && rdy0) got0.push_back({tuser0, tdata0});
        if (!reset && tvalid1 && rdy1) got1.push_back({tuser1, tdata1});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All stimulus tasks start and end just after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int inst, input logic v);
        if (inst == 0) rx0 = v;
        else           rx1 = v;
    endtask

    // Model FIFO: entries not yet seen on the handshake occupy the buffer.
    task automatic model_push(input int inst, input logic [10:0] e);
        if (inst == 0) begin
            if (exp0.size() - got0.size() >= DEPTH) ovf0_m = 1'b1;
            else                                    exp0.push_back(e);
        end else begin
            exp1.push_back(e);
        end
    endtask

    // glitch_at: clock index within the frame where the line is inverted (-1 = none).
    task automatic send_frame(input int inst, input logic [7:0] d, input logic par_flip,
                              input logic stop_v, input int glitch_at);
        logic [10:0] bits;
        logic        par, pe, fe, brk;
        int          n;
        par       = (^d) ^ par_flip;
        bits      = '0;
        bits[8:1] = d;
        if (inst == 1) begin
            bits[9]  = par;
            bits[10] = stop_v;
            n        = 11;
        end else begin
            bits[9] = stop_v;
            n       = 10;
        end
        pe  = (inst == 1) && par_flip;
        fe  = !stop_v;
        brk = (d == 8'h00) && (inst == 0 || !par) && !stop_v;
        model_push(inst, {brk, fe, pe, d});
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < CPB; c++) begin
                drive(inst, bits[i] ^ ((i * CPB + c) == glitch_at));
                tick(1);
            end
        end
        drive(inst, 1'b1);
        tick(24);
    endtask

    task automatic compare_q(input string tag);
        check_eq({tag, " count0"}, got0.size(), exp0.size());
        for (int i = 0; i < got0.size() && i < exp0.size(); i++)
            check_eq($sformatf("%s n-beat%0d", tag, i), got0[i], exp0[i]);
        check_eq({tag, " count1"}, got1.size(), exp1.size());
        for (int i = 0; i < got1.size() && i < exp1.size(); i++)
            check_eq($sformatf("%s e-beat%0d", tag, i), got1[i], exp1[i]);
        exp0.delete();
        got0.delete();
        exp1.delete();
        got1.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        reset  = 1'b1;
        rx0    = 1'b1;
        rx1    = 1'b1;
        rdy0   = 1'b1;
        rdy1   = 1'b1;
        clr0   = 1'b0;
        clr1   = 1'b0;
        ovf0_m = 1'b0;
        tick(3);
        check_eq("rst tvalid", tvalid0, 0);
        check_eq("rst ovf", ovf0, 0);
        check_eq("rst busy", busy0, 0);
        check_eq("rst tdata", tdata0, 0);
        check_eq("rst tuser", tuser0, 0);
        check_eq("rst tvalid e", tvalid1, 0);
        reset = 1'b0;
        tick(5);
        check_eq("idle busy", busy0, 0);

        // Clean frames in both modes.
        send_frame(0, 8'hA5, 1'b0, 1'b1, -1);
        check_eq("a5 ovf", ovf0, 0);
        send_frame(1, 8'h03, 1'b0, 1'b1, -1);
        send_frame(1, 8'h03, 1'b1, 1'b1, -1);
        compare_q("basic");

        // Short low pulse is a false start; single-cycle spike inside data bit 3.
        drive(0, 1'b0);
        tick(4);
        drive(0, 1'b1);
        tick(12);
        check_eq("false start busy", busy0, 0);
        tick(20);
        send_frame(0, 8'h00, 1'b0, 1'b1, 4 * CPB + 8);
        compare_q("glitch");

        // Overflow with a stalled consumer.
        rdy0 = 1'b0;
        for (int k = 0; k < 5; k++) send_frame(0, 8'h11 + 8'(k), 1'b0, 1'b1, -1);
        check_eq("ovf tvalid", tvalid0, 1);
        check_eq("ovf head", tdata0, 8'h11);
        check_eq("ovf set", ovf0, ovf0_m);
        rdy0 = 1'b1;
        tick(10);
        check_eq("ovf sticky", ovf0, ovf0_m);
        clr0 = 1'b1;
        tick(1);
        clr0   = 1'b0;
        ovf0_m = 1'b0;
        check_eq("ovf clear", ovf0, ovf0_m);
        compare_q("ovf");

        // Framing error, then a long break.
        send_frame(0, 8'h5A, 1'b0, 1'b0, -1);
        model_push(0, {3'b110, 8'h00});
        drive(0, 1'b0);
        tick(20 * CPB);
        check_eq("break busy a", busy0, 1);
        tick(10 * CPB);
        check_eq("break busy b", busy0, 1);
        drive(0, 1'b1);
        tick(8);
        check_eq("break released", busy0, 0);
        tick(24);
        compare_q("break");

        // Reset in the middle of data bit 4 with an entry waiting in the FIFO.
        rdy0 = 1'b0;
        send_frame(0, 8'h77, 1'b0, 1'b1, -1);
        check_eq("pre-rst tvalid", tvalid0, 1);
        d = 8'h1F;
        drive(0, 1'b0);
        tick(CPB);
        for (int b = 0; b < 4; b++) begin
            drive(0, d[b]);
            tick(CPB);
        end
        drive(0, d[4]);
        tick(8);
        reset = 1'b1;
        drive(0, 1'b1);
        tick(2);
        reset = 1'b0;
        while (exp0.size() > got0.size()) void'(exp0.pop_back());
        tick(1);
        check_eq("midrst tvalid", tvalid0, 0);
        check_eq("midrst busy", busy0, 0);
        check_eq("midrst ovf", ovf0, 0);
        rdy0 = 1'b1;
        tick(2 * CPB);
        check_eq("midrst idle", busy0, 0);
        send_frame(0, 8'h3C, 1'b0, 1'b1, -1);
        compare_q("reset");

        // Random frames on both receivers, occasional parity and stop errors.
        for (int k = 0; k < 16; k++) begin
            send_frame($urandom_range(0, 1), 8'($urandom), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3) != 0, -1);
        end
        compare_q("rand");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
